tape_sdram_arb: RTL and testbench

//  Shares the single byte-wide SDRAM read port between the cassette tape

---
 rtl/tape_sdram_arb_if.sv | 32 +++
 rtl/tape_sdram_arb.sv | 110 +++++++++++
 tb/tb_tape_sdram_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tape_sdram_arb_if.sv
// tape_sdram_arb_if
//   Bundles the two requester channels and the SDRAM read channel of
//   tape_sdram_arb.
//   slave  : arbiter view. It takes the requests and sdram_data, and drives
//            the acks, rd_data, sdram_addr, sdram_rd, busy and owner.
//   master : the environment view (requesters plus SDRAM controller).
interface tape_sdram_arb_if #(
    parameter int AW = 25
);
    logic          req0_rd;
    logic [AW-1:0] req0_addr;
    logic          req0_ack;
    logic          req1_rd;
    logic [AW-1:0] req1_addr;
    logic          req1_ack;
    logic [7:0]    rd_data;
    logic [AW-1:0] sdram_addr;
    logic          sdram_rd;
    logic [7:0]    sdram_data;
    logic          busy;
    logic          owner;

    modport slave (
        input  req0_rd, req0_addr, req1_rd, req1_addr, sdram_data,
        output req0_ack, req1_ack, rd_data, sdram_addr, sdram_rd, busy, owner
    );

    modport master (
        output req0_rd, req0_addr, req1_rd, req1_addr, sdram_data,
        input  req0_ack, req1_ack, rd_data, sdram_addr, sdram_rd, busy, owner
    );
endinterface

// File: rtl/tape_sdram_arb.sv
// tape_sdram_arb
//   Two-way round-robin arbiter in front of the byte-wide SDRAM read port.
//   It serves the tape player (req0) and a second reader (req1). Each access
//   runs IDLE -> ISSUE -> WAIT x RD_LAT -> DONE, so it takes RD_LAT+3 cycles.
//   Ports:
//     clk      system clock (posedge)
//     reset_n  asynchronous active-low reset
//     bus      tape_sdram_arb_if.slave, which carries:
//              req0/req1 rd+addr in, req0/req1 ack out,
//              rd_data out, sdram_addr/sdram_rd out, sdram_data in,
//              busy out, owner out
//   Parameters:
//     AW      SDRAM byte address width
//     RD_LAT  cycles from sdram_rd to valid sdram_data (1..15)
module tape_sdram_arb #(
    parameter int AW     = 25,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    tape_sdram_arb_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          win;

    // On a tie, the requester that did not get the last completed access
    // wins. last_q resets to 1, so req0 takes the first tie.
    always_comb begin
        if (bus.req0_rd && bus.req1_rd) win = ~last_q;
        else                            win = bus.req1_rd;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next state and datapath next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_rd || bus.req1_rd) begin
                    owner_d = win;
                    addr_d  = win ? bus.req1_addr : bus.req0_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = bus.sdram_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Strobes are decoded from the state register, so each is
    // exactly one cycle wide and cannot repeat back to back.
    always_comb begin
        bus.sdram_rd   = (state_q == ISSUE);
        bus.req0_ack   = (state_q == DONE) && !owner_q;
        bus.req1_ack   = (state_q == DONE) &&  owner_q;
        bus.busy       = (state_q != IDLE);
        bus.owner      = owner_q;
        bus.sdram_addr = addr_q;
        bus.rd_data    = data_q;
    end

endmodule

// File: tb/tb_tape_sdram_arb.sv
// tb_tape_sdram_arb
//   Scoreboard bench for tape_sdram_arb. There are three instances with
//   RD_LAT = 2, 1 and 7. The stimulus pushes the expected acks, each with
//   its requester, byte, address and cycle. A monitor per instance pops one
//   entry on every ack and compares it. Each instance has an SDRAM model that
//   drives the byte only in the exact capture cycle and 0 at all other times.
module tb_tape_sdram_arb;
    localparam int AW = 25;

    typedef struct {
        logic          who;
        logic [7:0]    data;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    exp_t sbq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tape_sdram_arb_if #(.AW(AW)) bus[3] ();

    function automatic logic [7:0] fdat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int k, input logic who, input logic [AW-1:0] a,
                        input logic [7:0] d, input int c);
        exp_t e;
        e.who = who; e.data = d; e.addr = a; e.cyc = c;
        sbq[k].push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    for (genvar i = 0; i < 3; i++) begin : g_inst
        localparam int L = (i == 0) ? 2 : ((i == 1) ? 1 : 7);
        logic [15:0]   hist    = '0;
        logic [AW-1:0] ah [16];
        logic          prev_rd = 1'b0;
        exp_t          e;

        tape_sdram_arb #(.AW(AW), .RD_LAT(L)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus[i])
        );

        // SDRAM model: the byte for the strobed address appears in exactly
        // one cycle, L cycles after the sdram_rd cycle.
        always @(posedge clk) begin
            hist  <= {hist[14:0], bus[i].sdram_rd};
            ah[0] <= bus[i].sdram_addr;
            for (int j = 1; j < 16; j++) ah[j] <= ah[j-1];
        end
        assign bus[i].sdram_data = hist[L-1] ? fdat(ah[L-1]) : 8'h00;

        always @(negedge clk) begin
            if (bus[i].sdram_rd && prev_rd) begin
                n_chk++;
                $display("FAIL i%0d sdram_rd_2cyc: high two cycles at cyc %0d, required single pulse", i, cyc);
            end
            prev_rd = bus[i].sdram_rd;
            if (bus[i].req0_ack && bus[i].req1_ack) begin
                n_chk++;
                $display("FAIL i%0d both_acks: both acks high at cyc %0d, required at most one", i, cyc);
            end else if (bus[i].req0_ack || bus[i].req1_ack) begin
                if (sbq[i].size() == 0) begin
                    n_chk++;
                    $display("FAIL i%0d unexpected_ack: ack at cyc %0d, required none", i, cyc);
                end else begin
                    e = sbq[i].pop_front();
                    check($sformatf("i%0d ack_who", i),  32'(bus[i].req1_ack), 32'(e.who));
                    check($sformatf("i%0d owner", i),    32'(bus[i].owner), 32'(e.who));
                    check($sformatf("i%0d rd_data", i),  32'(bus[i].rd_data), 32'(e.data));
                    check($sformatf("i%0d sdram_addr", i), 32'(bus[i].sdram_addr), 32'(e.addr));
                    check($sformatf("i%0d ack_cycle", i), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic idle_all();
        bus[0].req0_rd = 1'b0; bus[0].req1_rd = 1'b0; bus[0].req0_addr = '0; bus[0].req1_addr = '0;
        bus[1].req0_rd = 1'b0; bus[1].req1_rd = 1'b0; bus[1].req0_addr = '0; bus[1].req1_addr = '0;
        bus[2].req0_rd = 1'b0; bus[2].req1_rd = 1'b0; bus[2].req0_addr = '0; bus[2].req1_addr = '0;
    endtask

    initial begin
        int c;
        idle_all();
        #2 reset_n = 1'b0;
        step(3);
        // Reset state
        check("rst busy",       32'(bus[0].busy), 0);
        check("rst sdram_rd",   32'(bus[0].sdram_rd), 0);
        check("rst req0_ack",   32'(bus[0].req0_ack), 0);
        check("rst req1_ack",   32'(bus[0].req1_ack), 0);
        check("rst rd_data",    32'(bus[0].rd_data), 0);
        check("rst owner",      32'(bus[0].owner), 0);
        check("rst sdram_addr", 32'(bus[0].sdram_addr), 0);
        reset_n = 1'b1;
        step(2);

        // 1. Single tape read
        bus[0].req0_addr = 25'h10; bus[0].req0_rd = 1'b1; c = cyc;
        push(0, 1'b0, 25'h10, 8'hA5, c + 4);
        step(1);
        check("t1 sdram_rd pulse", 32'(bus[0].sdram_rd), 1);
        check("t1 sdram_addr",     32'(bus[0].sdram_addr), 32'h10);
        step(1);
        check("t1 sdram_rd low",   32'(bus[0].sdram_rd), 0);
        check("t1 busy",           32'(bus[0].busy), 1);
        step(2);
        bus[0].req0_rd = 1'b0;
        step(3);

        // 2. Tie straight after reset: 0,1,0,1 spaced 5 cycles
        reset_n = 1'b0; step(1); reset_n = 1'b1; step(1);
        bus[0].req0_addr = 25'h100; bus[0].req1_addr = 25'h200;
        bus[0].req0_rd = 1'b1; bus[0].req1_rd = 1'b1; c = cyc;
        push(0, 1'b0, 25'h100, 8'hB4, c + 4);
        push(0, 1'b1, 25'h200, 8'hB7, c + 9);
        push(0, 1'b0, 25'h100, 8'hB4, c + 14);
        push(0, 1'b1, 25'h200, 8'hB7, c + 19);
        step(14); bus[0].req0_rd = 1'b0;
        step(5);  bus[0].req1_rd = 1'b0;
        step(3);

        // 3. Address change after latch
        bus[0].req1_addr = 25'h300; bus[0].req1_rd = 1'b1; c = cyc;
        push(0, 1'b1, 25'h300, 8'hB6, c + 4);
        step(1); bus[0].req1_addr = 25'h301;
        step(1); check("t3 addr held", 32'(bus[0].sdram_addr), 32'h300);
        step(2); bus[0].req1_rd = 1'b0;
        step(2);

        // 4. Request dropped mid-access
        bus[0].req0_addr = 25'h55; bus[0].req0_rd = 1'b1; c = cyc;
        push(0, 1'b0, 25'h55, 8'hE0, c + 4);
        step(2); bus[0].req0_rd = 1'b0;
        step(6);
        check("t4 idle busy",     32'(bus[0].busy), 0);
        check("t4 idle sdram_rd", 32'(bus[0].sdram_rd), 0);
        check("t4 rd_data held",  32'(bus[0].rd_data), 32'hE0);

        // 5. Reset in WAIT; next tie goes to req0
        bus[0].req0_addr = 25'h40; bus[0].req0_rd = 1'b1;
        step(2);
        reset_n = 1'b0; bus[0].req0_rd = 1'b0;
        #1;
        check("t5 busy",     32'(bus[0].busy), 0);
        check("t5 sdram_rd", 32'(bus[0].sdram_rd), 0);
        check("t5 rd_data",  32'(bus[0].rd_data), 0);
        check("t5 req0_ack", 32'(bus[0].req0_ack), 0);
        step(1); reset_n = 1'b1;
        step(8);
        bus[0].req0_addr = 25'h100; bus[0].req1_addr = 25'h200;
        bus[0].req0_rd = 1'b1; bus[0].req1_rd = 1'b1; c = cyc;
        push(0, 1'b0, 25'h100, 8'hB4, c + 4);
        push(0, 1'b1, 25'h200, 8'hB7, c + 9);
        step(4); bus[0].req0_rd = 1'b0;
        step(5); bus[0].req1_rd = 1'b0;
        step(3);
        check("t5 rd_data stable", 32'(bus[0].rd_data), 32'hB7);
        check("t5 owner last",     32'(bus[0].owner), 1);

        // 6. Latency sweep: RD_LAT=1 and RD_LAT=7
        bus[1].req0_addr = 25'h10;   bus[1].req0_rd = 1'b1;
        bus[2].req1_addr = 25'h1234; bus[2].req1_rd = 1'b1; c = cyc;
        push(1, 1'b0, 25'h10,   8'hA5, c + 3);
        push(2, 1'b1, 25'h1234, 8'h93, c + 9);
        step(3); bus[1].req0_rd = 1'b0;
        step(6); bus[2].req1_rd = 1'b0;
        step(4);

        check("sbq0 drained", 32'(sbq[0].size()), 0);
        check("sbq1 drained", 32'(sbq[1].size()), 0);
        check("sbq2 drained", 32'(sbq[2].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
